acc_sample_assembler: RTL and testbench

Downstream consumer of the accelerometer I2C master. Takes the received byte stream of a 6-byte burst read (X_L, X_H, Y_L, Y_H, Z_L, Z_H) and assembles it into signed 16-bit X/Y/Z samples. Subtracts per-axis offsets learned in an on-demand calibration phase. Feeds the attitude/flight-control logic with one-cycle sample strobes.

---
 rtl/acc_sample_assembler_pkg.sv | 34 +++
 rtl/acc_sample_assembler_if.sv | 28 ++
 rtl/acc_sample_assembler_offset_cal.sv | 106 ++++++++++
 rtl/acc_sample_assembler.sv | 93 +++++++++
 tb/tb_acc_sample_assembler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/acc_sample_assembler_pkg.sv
// Shared types, byte-slot map and saturation helper for the accelerometer sample assembler.
package acc_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_CAL,
        S_CAL_FIN
    } state_e;

    localparam int unsigned X_L         = 0;
    localparam int unsigned X_H         = 1;
    localparam int unsigned Y_L         = 2;
    localparam int unsigned Y_H         = 3;
    localparam int unsigned Z_L         = 4;
    localparam int unsigned Z_H         = 5;
    localparam int unsigned FRAME_BYTES = 6;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned SAMPLE_W    = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] x;
        logic signed [SAMPLE_W-1:0] y;
        logic signed [SAMPLE_W-1:0] z;
    } acc_vec_t;

    // Clamp a 17-bit signed difference into the 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7FFF;
        end
        return 16'(v);
    endfunction

endpackage

// File: rtl/acc_sample_assembler_if.sv
// Byte-stream input / calibrated-sample output bundle of the sample assembler.
interface acc_sample_assembler_if;
    import acc_pkg::*;

    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic                       frame_start;
    logic                       frame_abort;
    logic                       cal_req;
    logic signed [SAMPLE_W-1:0] acc_x;
    logic signed [SAMPLE_W-1:0] acc_y;
    logic signed [SAMPLE_W-1:0] acc_z;
    logic                       sample_valid;
    logic                       frame_err;
    logic                       cal_busy;
    logic                       cal_done;

    modport master (
        output byte_valid, byte_data, frame_start, frame_abort, cal_req,
        input  acc_x, acc_y, acc_z, sample_valid, frame_err, cal_busy, cal_done
    );

    modport slave (
        input  byte_valid, byte_data, frame_start, frame_abort, cal_req,
        output acc_x, acc_y, acc_z, sample_valid, frame_err, cal_busy, cal_done
    );

endinterface

// File: rtl/acc_sample_assembler_offset_cal.sv
// Offset calibration: averages 2^CAL_SHIFT raw frames into per-axis offsets.
// Build option ACC_ZGRAV_EN: Z offset leaves +ONE_G of gravity in the output.
module acc_offset_cal
    import acc_pkg::*;
#(
    parameter int unsigned CAL_SHIFT = 4,
    parameter int          ONE_G     = 256
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     frame_done,
    input  acc_vec_t raw,
    input  logic     start,
    output logic     busy,
    output logic     done,
    output acc_vec_t offset
);

    localparam int unsigned ACC_W  = SAMPLE_W + CAL_SHIFT;
    localparam int unsigned CNT_W  = CAL_SHIFT + 1;
    localparam int unsigned FRAMES = 1 << CAL_SHIFT;
`ifdef ACC_ZGRAV_EN
    localparam bit ZGRAV_EN = 1'b1;
`else
    localparam bit ZGRAV_EN = 1'b0;
`endif
    localparam int Z_BIAS = ZGRAV_EN ? ONE_G : 0;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic                     busy_q, busy_d, done_q, done_d;
    acc_vec_t                 off_q, off_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            acc_x_q <= '0;
            acc_y_q <= '0;
            acc_z_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            acc_z_q <= acc_z_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        acc_z_d = acc_z_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        off_d   = off_q;
        unique case (state_q)
            S_RUN: begin
                if (start) begin
                    state_d = S_CAL;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    acc_z_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_CAL: begin
                if (frame_done) begin
                    acc_x_d = acc_x_q + ACC_W'(raw.x);
                    acc_y_d = acc_y_q + ACC_W'(raw.y);
                    acc_z_d = acc_z_q + ACC_W'(raw.z);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAMES - 1)) begin
                        state_d = S_CAL_FIN;
                    end
                end
            end
            S_CAL_FIN: begin
                // Arithmetic shift floors the average toward -inf.
                off_d.x = 16'(acc_x_q >>> CAL_SHIFT);
                off_d.y = 16'(acc_y_q >>> CAL_SHIFT);
                off_d.z = sat16(17'(acc_z_q >>> CAL_SHIFT) - 17'(Z_BIAS));
                state_d = S_RUN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign offset = off_q;

endmodule

// File: rtl/acc_sample_assembler.sv
// Assembles 6-byte accelerometer bursts into offset-corrected signed X/Y/Z samples.
// Build option ACC_ZGRAV_EN (see acc_offset_cal) keeps +1 g on Z after calibration.
module acc_sample_assembler
    import acc_pkg::*;
#(
    parameter int unsigned CAL_SHIFT = 4,
    parameter int          ONE_G     = 256
) (
    input logic                   clk12M,
    input logic                   rst_n,
    acc_sample_assembler_if.slave bus
);

    logic [IDX_W-1:0] idx_q, idx_d, cur_idx_c;
    logic [7:0]       byte_q [FRAME_BYTES-1];
    logic [7:0]       byte_d [FRAME_BYTES-1];
    acc_vec_t         out_q, out_d, raw_c, off;
    logic             sv_q, sv_d, fe_q, fe_d;
    logic             restart_c, accept_c, frame_done_c;
    logic             cal_busy, cal_done;

    always_ff @(posedge clk12M or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            byte_q <= '{default: '0};
            out_q  <= '0;
            sv_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            byte_q <= byte_d;
            out_q  <= out_d;
            sv_q   <= sv_d;
            fe_q   <= fe_d;
        end
    end

    always_comb begin
        restart_c    = bus.frame_start || bus.frame_abort;
        cur_idx_c    = restart_c ? '0 : idx_q;
        accept_c     = bus.byte_valid && !bus.frame_abort;
        frame_done_c = accept_c && (cur_idx_c == IDX_W'(Z_H));
        // Byte 5 goes straight from the bus so the frame completes on its strobe.
        raw_c.x      = {byte_q[X_H], byte_q[X_L]};
        raw_c.y      = {byte_q[Y_H], byte_q[Y_L]};
        raw_c.z      = {bus.byte_data, byte_q[Z_L]};

        idx_d  = idx_q;
        byte_d = byte_q;
        out_d  = out_q;
        sv_d   = 1'b0;
        fe_d   = restart_c && (idx_q != '0);

        if (restart_c) begin
            idx_d = '0;
        end
        if (frame_done_c) begin
            idx_d = '0;
            if (!cal_busy) begin
                out_d.x = sat16(17'(raw_c.x) - 17'(off.x));
                out_d.y = sat16(17'(raw_c.y) - 17'(off.y));
                out_d.z = sat16(17'(raw_c.z) - 17'(off.z));
                sv_d    = 1'b1;
            end
        end else if (accept_c) begin
            byte_d[cur_idx_c] = bus.byte_data;
            idx_d             = cur_idx_c + 1'b1;
        end
    end

    acc_offset_cal #(
        .CAL_SHIFT (CAL_SHIFT),
        .ONE_G     (ONE_G)
    ) u_offset_cal (
        .clk        (clk12M),
        .rst_n      (rst_n),
        .frame_done (frame_done_c),
        .raw        (raw_c),
        .start      (bus.cal_req),
        .busy       (cal_busy),
        .done       (cal_done),
        .offset     (off)
    );

    assign bus.acc_x        = out_q.x;
    assign bus.acc_y        = out_q.y;
    assign bus.acc_z        = out_q.z;
    assign bus.sample_valid = sv_q;
    assign bus.frame_err    = fe_q;
    assign bus.cal_busy     = cal_busy;
    assign bus.cal_done     = cal_done;

endmodule

// File: tb/tb_acc_sample_assembler.sv
// Directed self-checking bench for acc_sample_assembler (CAL_SHIFT=4, ONE_G=256).
module tb_acc_sample_assembler;

    logic clk12M = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk12M = ~clk12M;

    acc_sample_assembler_if bus ();

    acc_sample_assembler #(
        .CAL_SHIFT (4),
        .ONE_G     (256)
    ) dut (
        .clk12M (clk12M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

`ifdef ACC_ZGRAV_EN
    localparam int Z_BIAS = 256;
`else
    localparam int Z_BIAS = 0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sv_cnt   = 0;
    int fe_cnt   = 0;
    int qx[$];
    int qy[$];
    int qz[$];
    int qc[$];

    // Pulse monitor: counts strobes and logs each emitted sample.
    always @(negedge clk12M) begin
        cyc++;
        if (bus.sample_valid === 1'b1) begin
            sv_cnt++;
            qx.push_back(int'(bus.acc_x));
            qy.push_back(int'(bus.acc_y));
            qz.push_back(int'(bus.acc_z));
            qc.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk12M);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk12M);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int x, input int y, input int z);
        logic [15:0] vx, vy, vz;
        vx = 16'(x);
        vy = 16'(y);
        vz = 16'(z);
        send_byte(vx[7:0]); send_byte(vx[15:8]);
        send_byte(vy[7:0]); send_byte(vy[15:8]);
        send_byte(vz[7:0]); send_byte(vz[15:8]);
    endtask

    task automatic pulse_cal();
        bus.cal_req = 1'b1;
        @(negedge clk12M);
        bus.cal_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (bus.acc_x !== 16'sd0) begin failures++; $display("FAIL reset_acc_x got=%0d exp=0", bus.acc_x); end
        checks++; if (bus.acc_y !== 16'sd0) begin failures++; $display("FAIL reset_acc_y got=%0d exp=0", bus.acc_y); end
        checks++; if (bus.acc_z !== 16'sd0) begin failures++; $display("FAIL reset_acc_z got=%0d exp=0", bus.acc_z); end
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sample_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
        checks++; if (bus.cal_busy !== 1'b0) begin failures++; $display("FAIL reset_cal_busy got=%b exp=0", bus.cal_busy); end
        checks++; if (bus.cal_done !== 1'b0) begin failures++; $display("FAIL reset_cal_done got=%b exp=0", bus.cal_done); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hFE); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h01);
        checks++; if (bus.sample_valid !== 1'b1) begin failures++; $display("FAIL basic_latency sample_valid got=%b exp=1", bus.sample_valid); end
        checks++; if (int'(bus.acc_x) !== 32'sh1234) begin failures++; $display("FAIL basic_acc_x got=%0d exp=%0d", bus.acc_x, 32'sh1234); end
        checks++; if (int'(bus.acc_y) !== -2) begin failures++; $display("FAIL basic_acc_y got=%0d exp=-2", bus.acc_y); end
        checks++; if (int'(bus.acc_z) !== 256) begin failures++; $display("FAIL basic_acc_z got=%0d exp=256", bus.acc_z); end
        @(negedge clk12M);
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width sample_valid got=%b exp=0", bus.sample_valid); end
        idle(2);
    endtask

    task automatic test_frame_start();
        int bsv, bfe, bq;
        bsv = sv_cnt; bfe = fe_cnt; bq = qx.size();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        bus.frame_start = 1'b1;
        send_byte(8'h78);
        bus.frame_start = 1'b0;
        send_byte(8'h56); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hFD); send_byte(8'hFF);
        idle(3);
        checks++; if (fe_cnt - bfe !== 1) begin failures++; $display("FAIL start_frame_err_count got=%0d exp=1", fe_cnt - bfe); end
        checks++; if (sv_cnt - bsv !== 1) begin failures++; $display("FAIL start_sample_count got=%0d exp=1", sv_cnt - bsv); end
        checks++; if (qx.size() != bq + 1 || qx[bq] !== 32'sh5678) begin failures++; $display("FAIL start_acc_x got=%0d exp=%0d", (qx.size() > bq) ? qx[bq] : 0, 32'sh5678); end
        checks++; if (qy.size() != bq + 1 || qy[bq] !== 2) begin failures++; $display("FAIL start_acc_y got=%0d exp=2", (qy.size() > bq) ? qy[bq] : 0); end
        checks++; if (qz.size() != bq + 1 || qz[bq] !== -3) begin failures++; $display("FAIL start_acc_z got=%0d exp=-3", (qz.size() > bq) ? qz[bq] : 0); end
    endtask

    task automatic test_abort();
        int bsv, bfe, bq;
        bsv = sv_cnt; bfe = fe_cnt; bq = qx.size();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        bus.frame_abort = 1'b1;
        send_byte(8'hAA);
        bus.frame_abort = 1'b0;
        send_frame(10, 20, 30);
        idle(3);
        checks++; if (fe_cnt - bfe !== 1) begin failures++; $display("FAIL abort_frame_err_count got=%0d exp=1", fe_cnt - bfe); end
        checks++; if (sv_cnt - bsv !== 1) begin failures++; $display("FAIL abort_sample_count got=%0d exp=1", sv_cnt - bsv); end
        checks++; if (qx.size() != bq + 1 || qx[bq] !== 10) begin failures++; $display("FAIL abort_acc_x got=%0d exp=10", (qx.size() > bq) ? qx[bq] : 0); end
        checks++; if (qy.size() != bq + 1 || qy[bq] !== 20) begin failures++; $display("FAIL abort_acc_y got=%0d exp=20", (qy.size() > bq) ? qy[bq] : 0); end
        checks++; if (qz.size() != bq + 1 || qz[bq] !== 30) begin failures++; $display("FAIL abort_acc_z got=%0d exp=30", (qz.size() > bq) ? qz[bq] : 0); end
    endtask

    task automatic test_cal();
        int bsv, busy_bad;
        bsv = sv_cnt; busy_bad = 0;
        pulse_cal();
        for (int i = 0; i < 16; i++) begin
            if (bus.cal_busy !== 1'b1) busy_bad++;
            if (i == 8) pulse_cal();
            send_frame(100, -50, 300);
        end
        if (bus.cal_busy !== 1'b1) busy_bad++;
        idle(3);
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL cal_busy_during got=%0d low samples exp=0", busy_bad); end
        checks++; if (sv_cnt - bsv !== 0) begin failures++; $display("FAIL cal_no_samples got=%0d exp=0", sv_cnt - bsv); end
        checks++; if (bus.cal_busy !== 1'b0) begin failures++; $display("FAIL cal_busy_after got=%b exp=0", bus.cal_busy); end
        checks++; if (bus.cal_done !== 1'b1) begin failures++; $display("FAIL cal_done_after got=%b exp=1", bus.cal_done); end
        send_frame(100, -50, 300);
        idle(2);
        checks++; if (int'(bus.acc_x) !== 0) begin failures++; $display("FAIL cal_acc_x got=%0d exp=0", bus.acc_x); end
        checks++; if (int'(bus.acc_y) !== 0) begin failures++; $display("FAIL cal_acc_y got=%0d exp=0", bus.acc_y); end
        checks++; if (int'(bus.acc_z) !== Z_BIAS) begin failures++; $display("FAIL cal_acc_z got=%0d exp=%0d", bus.acc_z, Z_BIAS); end
    endtask

    task automatic test_saturation();
        send_frame(-32768, -50, 300);
        idle(2);
        checks++; if (int'(bus.acc_x) !== -32768) begin failures++; $display("FAIL sat_neg_acc_x got=%0d exp=-32768", bus.acc_x); end
        checks++; if (int'(bus.acc_y) !== 0) begin failures++; $display("FAIL sat_neg_acc_y got=%0d exp=0", bus.acc_y); end
        pulse_cal();
        for (int i = 0; i < 16; i++) send_frame(-100, 0, 0);
        idle(3);
        send_frame(32767, 5, 7);
        idle(2);
        checks++; if (int'(bus.acc_x) !== 32767) begin failures++; $display("FAIL sat_pos_acc_x got=%0d exp=32767", bus.acc_x); end
        checks++; if (int'(bus.acc_y) !== 5) begin failures++; $display("FAIL sat_pos_acc_y got=%0d exp=5", bus.acc_y); end
        checks++; if (int'(bus.acc_z) !== 7 + Z_BIAS) begin failures++; $display("FAIL sat_pos_acc_z got=%0d exp=%0d", bus.acc_z, 7 + Z_BIAS); end
    endtask

    task automatic test_reset_mid_cal();
        pulse_cal();
        for (int i = 0; i < 7; i++) send_frame(1000, 1000, 1000);
        rst_n = 1'b0;
        idle(2);
        checks++; if (bus.cal_busy !== 1'b0) begin failures++; $display("FAIL midcal_reset_busy got=%b exp=0", bus.cal_busy); end
        checks++; if (bus.cal_done !== 1'b0) begin failures++; $display("FAIL midcal_reset_done got=%b exp=0", bus.cal_done); end
        rst_n = 1'b1;
        idle(2);
        send_frame(1000, 2000, 3000);
        idle(2);
        checks++; if (int'(bus.acc_x) !== 1000) begin failures++; $display("FAIL midcal_acc_x got=%0d exp=1000", bus.acc_x); end
        checks++; if (int'(bus.acc_y) !== 2000) begin failures++; $display("FAIL midcal_acc_y got=%0d exp=2000", bus.acc_y); end
        checks++; if (int'(bus.acc_z) !== 3000) begin failures++; $display("FAIL midcal_acc_z got=%0d exp=3000", bus.acc_z); end
    endtask

    task automatic test_back_to_back();
        int bsv, bq;
        bsv = sv_cnt; bq = qx.size();
        send_frame(1, -1, 2);
        send_frame(-300, 400, 32767);
        idle(3);
        checks++; if (sv_cnt - bsv !== 2) begin failures++; $display("FAIL b2b_sample_count got=%0d exp=2", sv_cnt - bsv); end
        if (qx.size() == bq + 2) begin
            checks++; if (qc[bq + 1] - qc[bq] !== 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", qc[bq + 1] - qc[bq]); end
            checks++; if (qx[bq] !== 1 || qy[bq] !== -1 || qz[bq] !== 2) begin failures++; $display("FAIL b2b_frame0 got=(%0d,%0d,%0d) exp=(1,-1,2)", qx[bq], qy[bq], qz[bq]); end
            checks++; if (qx[bq + 1] !== -300 || qy[bq + 1] !== 400 || qz[bq + 1] !== 32767) begin failures++; $display("FAIL b2b_frame1 got=(%0d,%0d,%0d) exp=(-300,400,32767)", qx[bq + 1], qy[bq + 1], qz[bq + 1]); end
        end
    endtask

    initial begin
        bus.byte_valid  = 1'b0;
        bus.byte_data   = 8'h00;
        bus.frame_start = 1'b0;
        bus.frame_abort = 1'b0;
        bus.cal_req     = 1'b0;
        @(negedge clk12M);
        test_reset();
        test_basic();
        test_frame_start();
        test_abort();
        test_cal();
        test_saturation();
        test_reset_mid_cal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
